multicycle_processor: RTL

Parametrised multicycle successor to the single-cycle ARM-subset core: one shared instruction/data memory port with a ready handshake instead of separate instruction and data buses, an explicit control FSM, and full NZCV condition handling. Sits between the system bus/memory model and the top-level testbench. One instruction completes per 2–5 cycles plus memory wait states.

---
 rtl/multicycle_processor.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_processor.sv
// multicycle_processor
//   Multicycle ARM-subset core with a single shared instruction/data memory
//   port using a req/ready handshake. One instruction takes 2-5 cycles plus
//   memory wait states.
//
//   Parameters
//     RESET_PC       PC value loaded on reset
//     HALT_ON_UNDEF  1: undefined encoding halts, 0: treated as a NOP
//   Ports
//     clk            rising-edge clock
//     reset          synchronous active-low reset
//     mem_req        access request, held until mem_ready
//     mem_we         1 = write, 0 = read
//     mem_addr       word-aligned byte address
//     mem_wdata      store data
//     mem_rdata      read data, sampled when mem_ready=1
//     mem_ready      accept/complete strobe
//     pc             current PC register
//     halted         1 while in HALT
//
//   state   | meaning
//   FETCH   | read instruction at PC, IR <- data, PC <- PC+4
//   DECODE  | check condition and encoding, pick the path
//   EXEC    | data-processing ALU op, flag update
//   MEMADR  | compute Rn +/- imm12, word-aligned
//   MEMRD   | load request in flight
//   MEMWR   | store request in flight
//   WB_ALU  | write ALU result to Rd (CMP writes nothing)
//   WB_MEM  | write loaded data to Rd
//   BRANCH  | PC <- PC+4 + sext(imm24)<<2
//   HALT    | stopped until reset
module multicycle_processor #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter bit          HALT_ON_UNDEF = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        halted
);

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC, MEMADR, MEMRD, MEMWR, WB_ALU, WB_MEM, BRANCH, HALT
    } state_t;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    state_t      state;
    logic [31:0] regs [0:14];
    logic [31:0] ir;
    logic [31:0] data_reg;
    logic [31:0] alu_reg;
    logic [3:0]  nzcv;
    // Low for the first cycle after reset so no request is issued while
    // reset is still being held.
    logic        req_en;

    logic [3:0]  cond, cmd, rn, rd, rm;
    logic [4:0]  rot;
    logic [31:0] rn_val, rd_val, rm_val, imm_rot, src2, mem_ea, br_target;

    assign cond = ir[31:28];
    assign cmd  = ir[24:21];
    assign rn   = ir[19:16];
    assign rd   = ir[15:12];
    assign rm   = ir[3:0];
    assign rot  = {ir[11:8], 1'b0};

    // R15 reads see PC+4; PC already points past the instruction.
    assign rn_val = (rn == 4'd15) ? pc + 32'd4 : regs[rn];
    assign rd_val = (rd == 4'd15) ? pc + 32'd4 : regs[rd];
    assign rm_val = (rm == 4'd15) ? pc + 32'd4 : regs[rm];

    // A shift of 32 yields zero, so rot=0 needs no special case.
    assign imm_rot = ({24'd0, ir[7:0]} >> rot) | ({24'd0, ir[7:0]} << (6'd32 - {1'b0, rot}));
    assign src2    = ir[25] ? imm_rot : rm_val;

    assign mem_ea    = (ir[23] ? rn_val + {20'd0, ir[11:0]} : rn_val - {20'd0, ir[11:0]})
                       & 32'hFFFF_FFFC;
    assign br_target = pc + 32'd4 + {{6{ir[23]}}, ir[23:0], 2'b00};

    logic cond_ok;
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'h0: cond_ok = nzcv[2];
            4'h1: cond_ok = !nzcv[2];
            4'h2: cond_ok = nzcv[1];
            4'h3: cond_ok = !nzcv[1];
            4'h4: cond_ok = nzcv[3];
            4'h5: cond_ok = !nzcv[3];
            4'h6: cond_ok = nzcv[0];
            4'h7: cond_ok = !nzcv[0];
            4'h8: cond_ok = nzcv[1] && !nzcv[2];
            4'h9: cond_ok = !nzcv[1] || nzcv[2];
            4'hA: cond_ok = (nzcv[3] == nzcv[0]);
            4'hB: cond_ok = (nzcv[3] != nzcv[0]);
            4'hC: cond_ok = !nzcv[2] && (nzcv[3] == nzcv[0]);
            4'hD: cond_ok = nzcv[2] || (nzcv[3] != nzcv[0]);
            4'hE: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    logic dp_ok, mem_ok, undef;
    always_comb begin
        dp_ok  = (cmd == CMD_AND || cmd == CMD_SUB || cmd == CMD_ADD ||
                  cmd == CMD_CMP || cmd == CMD_ORR || cmd == CMD_MOV) &&
                 (ir[25] || ir[11:4] == 8'd0);
        mem_ok = !ir[25] && ir[24] && !ir[22] && !ir[21];
        undef  = 1'b0;
        case (ir[27:26])
            2'b00:   undef = !dp_ok;
            2'b01:   undef = !mem_ok;
            2'b10:   undef = 1'b0;
            default: undef = 1'b1;
        endcase
        if (cond == 4'hF)
            undef = 1'b1;
    end

    logic [32:0] sum, dif;
    logic [31:0] alu_res;
    logic        alu_c, alu_v;
    always_comb begin
        sum     = {1'b0, rn_val} + {1'b0, src2};
        dif     = {1'b0, rn_val} + {1'b0, ~src2} + 33'd1;
        alu_res = 32'd0;
        alu_c   = nzcv[1];
        alu_v   = nzcv[0];
        case (cmd)
            CMD_ADD: begin
                alu_res = sum[31:0];
                alu_c   = sum[32];
                alu_v   = (rn_val[31] == src2[31]) && (alu_res[31] != rn_val[31]);
            end
            CMD_SUB, CMD_CMP: begin
                alu_res = dif[31:0];
                alu_c   = dif[32];
                alu_v   = (rn_val[31] != src2[31]) && (alu_res[31] != rn_val[31]);
            end
            CMD_AND: alu_res = rn_val & src2;
            CMD_ORR: alu_res = rn_val | src2;
            CMD_MOV: alu_res = src2;
            default: alu_res = 32'd0;
        endcase
    end

    assign mem_req   = req_en && (state == FETCH || state == MEMRD || state == MEMWR);
    assign mem_we    = (state == MEMWR);
    assign mem_addr  = (state == FETCH) ? pc : alu_reg;
    assign mem_wdata = rd_val;
    assign halted    = (state == HALT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            nzcv     <= 4'd0;
            ir       <= 32'd0;
            data_reg <= 32'd0;
            alu_reg  <= 32'd0;
            req_en   <= 1'b0;
            for (int i = 0; i < 15; i++)
                regs[i] <= 32'd0;
        end else begin
            req_en <= 1'b1;
            case (state)
                FETCH: begin
                    if (mem_req && mem_ready) begin
                        ir    <= mem_rdata;
                        pc    <= pc + 32'd4;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (cond != 4'hF && !cond_ok)
                        state <= FETCH;
                    else if (undef)
                        state <= HALT_ON_UNDEF ? HALT : FETCH;
                    else begin
                        case (ir[27:26])
                            2'b00:   state <= EXEC;
                            2'b01:   state <= MEMADR;
                            default: state <= BRANCH;
                        endcase
                    end
                end
                EXEC: begin
                    alu_reg <= alu_res;
                    if (ir[20] || cmd == CMD_CMP)
                        nzcv <= {alu_res[31], alu_res == 32'd0, alu_c, alu_v};
                    state <= WB_ALU;
                end
                MEMADR: begin
                    alu_reg <= mem_ea;
                    state   <= ir[20] ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    if (mem_req && mem_ready) begin
                        data_reg <= mem_rdata;
                        state    <= WB_MEM;
                    end
                end
                MEMWR: begin
                    if (mem_req && mem_ready)
                        state <= FETCH;
                end
                WB_ALU: begin
                    if (cmd != CMD_CMP) begin
                        if (rd == 4'd15)
                            pc <= alu_reg;
                        else
                            regs[rd] <= alu_reg;
                    end
                    state <= FETCH;
                end
                WB_MEM: begin
                    if (rd == 4'd15)
                        pc <= data_reg;
                    else
                        regs[rd] <= data_reg;
                    state <= FETCH;
                end
                BRANCH: begin
                    pc    <= br_target;
                    state <= FETCH;
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

endmodule
